sound_fx_sequencer: RTL and testbench

- Upstream stage of the sound unit's sine-table address counter.
- On a one-cycle request, plays a short sound effect: a fixed list of (note, duration) steps.
- For each step it produces the slow "step" enable pulse (counter en input) at the rate for that note, and the sound-on gate (counter en1 input).
- Sits between the game logic (hit/shot/explosion events) and the address counter / sine ROM / audio output chain.

---
 rtl/sound_fx_pkg.sv | 74 +++++++
 rtl/sound_fx_rom.sv | 21 ++
 rtl/sound_fx_sequencer.sv | 136 +++++++++++++
 tb/tb_sound_fx_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sound_fx_pkg.sv
// rtl/sound_fx_pkg.sv - shared types, note dividers and effect step lists for the sound effect sequencer
package sound_fx_pkg;

    localparam int FX_DUR_W     = 8;
    localparam int FX_MAX_STEPS = 16;
    localparam int FX_STEP_W    = $clog2(FX_MAX_STEPS);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_PLAY} fx_state_t;

    typedef struct packed {
        logic [3:0]          note;
        logic [FX_DUR_W-1:0] dur;
        logic                last;
    } fx_step_t;

    localparam logic [3:0] REST  = 4'd0;
    localparam logic [3:0] C4    = 4'd1;
    localparam logic [3:0] D4    = 4'd2;
    localparam logic [3:0] E4    = 4'd3;
    localparam logic [3:0] F4    = 4'd4;
    localparam logic [3:0] G4    = 4'd5;
    localparam logic [3:0] A4    = 4'd6;
    localparam logic [3:0] B4    = 4'd7;
    localparam logic [3:0] C5    = 4'd8;
    localparam logic [3:0] D5    = 4'd9;
    localparam logic [3:0] E5    = 4'd10;
    localparam logic [3:0] F5    = 4'd11;
    localparam logic [3:0] G5    = 4'd12;
    localparam logic [3:0] A5    = 4'd13;
    localparam logic [3:0] B5    = 4'd14;
    localparam logic [3:0] CLICK = 4'd15;

    // round(50e6 / (f_note * 256)); CLICK's divider of 1 is too short to step and plays as a rest
    localparam logic [15:0] DIV_TABLE [16] = '{
        16'd0,   16'd747, 16'd665, 16'd593, 16'd559, 16'd498, 16'd444, 16'd395,
        16'd373, 16'd333, 16'd296, 16'd280, 16'd249, 16'd222, 16'd198, 16'd1
    };

    function automatic fx_step_t fx_step(input logic [3:0] note, input logic [FX_DUR_W-1:0] dur,
                                         input logic last);
        fx_step_t s;
        s.note = note;
        s.dur  = dur;
        s.last = last;
        return s;
    endfunction

    function automatic fx_step_t fx_lookup(input logic [1:0] effect, input logic [FX_STEP_W-1:0] step);
        fx_step_t s;
        s = fx_step(REST, 8'd0, 1'b1);
        case (effect)
            2'd0: if (step == 4'd0) s = fx_step(A4, 8'd2, 1'b1);
            2'd1: case (step)
                4'd0:    s = fx_step(C5, 8'd1, 1'b0);
                4'd1:    s = fx_step(REST, 8'd1, 1'b0);
                4'd2:    s = fx_step(A4, 8'd1, 1'b1);
                default: ;
            endcase
            2'd2: case (step)
                4'd0:    s = fx_step(C4, 8'd0, 1'b0);
                4'd1:    s = fx_step(CLICK, 8'd1, 1'b0);
                default: s = fx_step(step - 4'd1, 8'd1, 1'b0);
            endcase
            default: case (step)
                4'd0:    s = fx_step(G4, 8'd3, 1'b0);
                4'd1:    s = fx_step(E4, 8'd3, 1'b0);
                4'd2:    s = fx_step(C4, 8'd4, 1'b1);
                default: ;
            endcase
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sound_fx_rom.sv
// rtl/sound_fx_rom.sv - registered (effect, step) -> fx_step_t lookup, one cycle latency
module sound_fx_rom
    import sound_fx_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [1:0]           i_effect,
    input  logic [FX_STEP_W-1:0] i_step,
    output fx_step_t             o_step
);

    fx_step_t r_step;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_step <= '0;
        else         r_step <= fx_lookup(i_effect, i_step);
    end

    assign o_step = r_step;

endmodule

// File: rtl/sound_fx_sequencer.sv
// rtl/sound_fx_sequencer.sv - plays (note, duration) effect lists as step/sound enables for the sine address counter
module sound_fx_sequencer
    import sound_fx_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DUR_WIDTH = FX_DUR_W,
    parameter int MS_DIV    = 50000,
    parameter int MAX_STEPS = FX_MAX_STEPS
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic [1:0] effect_id,
    input  logic       stop,
    output logic       busy,
    output logic       step_en,
    output logic       sound_en,
    output logic [3:0] note_idx
);

    localparam int STEP_W = $clog2(MAX_STEPS);
    localparam int MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    fx_state_t            r_state, w_state_nxt;
    logic [1:0]           r_effect, w_effect_nxt;
    logic [STEP_W-1:0]    r_step, w_step_nxt;
    fx_step_t             w_rom;
    logic [DIV_WIDTH-1:0] r_div, r_presc, w_div_ld;
    logic [MS_W-1:0]      r_ms_cnt;
    logic [DUR_WIDTH-1:0] r_dur_cnt;
    logic                 r_rest, r_last;
    logic                 w_fetch_rest, w_ms_wrap, w_step_done, w_load, w_run;
    logic                 r_busy, r_step_en, r_sound_en;
    logic [3:0]           r_note_idx;

    // The ROM is addressed with next-state values so its registered output is valid during FETCH
    sound_fx_rom u_rom (
        .clk      (clk),
        .resetN   (resetN),
        .i_effect (w_effect_nxt),
        .i_step   (FX_STEP_W'(w_step_nxt)),
        .o_step   (w_rom)
    );

    assign w_div_ld     = DIV_WIDTH'(DIV_TABLE[w_rom.note]);
    assign w_fetch_rest = (w_rom.note == REST) || (w_div_ld < DIV_WIDTH'(2));
    assign w_ms_wrap    = (r_ms_cnt == MS_W'(MS_DIV - 1));
    assign w_step_done  = w_ms_wrap && (r_dur_cnt <= DUR_WIDTH'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_effect_nxt = r_effect;
        w_step_nxt   = r_step;
        case (r_state)
            ST_FETCH: w_state_nxt = ST_PLAY;
            ST_PLAY: if (w_step_done) begin
                if (r_last || (r_step == STEP_W'(MAX_STEPS - 1))) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FETCH;
                    w_step_nxt  = r_step + STEP_W'(1);
                end
            end
            default: ;
        endcase
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else if (start) begin
            w_state_nxt  = ST_FETCH;
            w_effect_nxt = effect_id;
            w_step_nxt   = '0;
        end
    end

    assign w_load = (r_state == ST_FETCH) && (w_state_nxt == ST_PLAY);
    assign w_run  = (r_state == ST_PLAY) && (w_state_nxt == ST_PLAY);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= ST_IDLE;
            r_effect <= '0;
            r_step   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_effect <= w_effect_nxt;
            r_step   <= w_step_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_div     <= '0;
            r_presc   <= '0;
            r_ms_cnt  <= '0;
            r_dur_cnt <= '0;
            r_rest    <= 1'b1;
            r_last    <= 1'b0;
        end else if (w_load) begin
            r_div     <= w_div_ld;
            r_presc   <= '0;
            r_ms_cnt  <= '0;
            r_dur_cnt <= (w_rom.dur == '0) ? DUR_WIDTH'(1) : DUR_WIDTH'(w_rom.dur);
            r_rest    <= w_fetch_rest;
            r_last    <= w_rom.last;
        end else if (w_run) begin
            r_presc  <= (r_presc == r_div - DIV_WIDTH'(1)) ? '0 : r_presc + DIV_WIDTH'(1);
            r_ms_cnt <= w_ms_wrap ? '0 : r_ms_cnt + MS_W'(1);
            if (w_ms_wrap && (r_dur_cnt > DUR_WIDTH'(1))) r_dur_cnt <= r_dur_cnt - DUR_WIDTH'(1);
        end else begin
            r_presc  <= '0;
            r_ms_cnt <= '0;
        end
    end

    // Outputs look one cycle ahead so step_en lands on the cycle the prescaler reads divider-1
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_busy     <= 1'b0;
            r_step_en  <= 1'b0;
            r_sound_en <= 1'b0;
            r_note_idx <= '0;
        end else begin
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_step_en  <= w_run && !r_rest && (r_presc == r_div - DIV_WIDTH'(2));
            r_sound_en <= (w_load && !w_fetch_rest) || (w_run && !r_rest);
            if (w_state_nxt == ST_IDLE) r_note_idx <= '0;
            else if (w_load)            r_note_idx <= w_rom.note;
        end
    end

    assign busy     = r_busy;
    assign step_en  = r_step_en;
    assign sound_en = r_sound_en;
    assign note_idx = r_note_idx;

endmodule

// File: tb/tb_sound_fx_sequencer.sv
// tb/tb_sound_fx_sequencer.sv - directed self-checking bench for sound_fx_sequencer (MS_DIV=1000)
module tb_sound_fx_sequencer;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] effect_id = 2'd0;
    logic       busy, step_en, sound_en;
    logic [3:0] note_idx;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sound_fx_sequencer #(
        .DIV_WIDTH (16),
        .DUR_WIDTH (8),
        .MS_DIV    (1000),
        .MAX_STEPS (16)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .effect_id (effect_id),
        .stop      (stop),
        .busy      (busy),
        .step_en   (step_en),
        .sound_en  (sound_en),
        .note_idx  (note_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After return the DUT is in its FETCH cycle (cycle 1 after start)
    task automatic pulse_start(input logic [1:0] id);
        start     = 1'b1;
        effect_id = id;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        int n_se, n_snd, first, prev, bad, n_rest, w;
        int se_w[3];
        int snd_w[3];

        repeat (3) tick();
        chk("reset_outputs", {busy, step_en, sound_en, note_idx}, 0);
        resetN = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Single step: A4 (div 444) for 2 ms
        pulse_start(2'd0);
        chk("t1_busy_fetch", busy, 1);
        chk("t1_sound_fetch", sound_en, 0);
        n_se = 0; n_snd = 0; first = 0; prev = 0; bad = 0;
        for (int k = 1; k <= 2001; k++) begin
            tick();
            if (k == 1) chk("t1_note", note_idx, 6);
            if (k == 2000) chk("t1_busy_last_play", busy, 1);
            if (step_en) begin
                n_se++;
                if (n_se == 1) first = k;
                else if (k - prev != 444) bad++;
                prev = k;
            end
            if (sound_en) n_snd++;
        end
        chk("t1_busy_done", busy, 0);
        chk("t1_pulse_count", n_se, 4);
        chk("t1_first_pulse", first, 444);
        chk("t1_bad_gaps", bad, 0);
        chk("t1_sound_cycles", n_snd, 2000);

        // C5, rest, A4 at 1 ms each
        pulse_start(2'd1);
        for (int i = 0; i < 3; i++) begin se_w[i] = 0; snd_w[i] = 0; end
        n_rest = 0;
        for (int j = 2; j <= 3004; j++) begin
            tick();
            w = (j <= 1001) ? 0 : (j <= 2003) ? 1 : 2;
            if (j <= 3003) begin
                se_w[w]  += int'(step_en);
                snd_w[w] += int'(sound_en);
            end
            if (busy && note_idx == 4'd0) n_rest++;
            if (j == 2)    chk("t2_note_c5", note_idx, 8);
            if (j == 1003) chk("t2_note_rest", note_idx, 0);
            if (j == 2004) chk("t2_note_a4", note_idx, 6);
            if (j == 3003) chk("t2_busy_last_play", busy, 1);
            if (j == 3004) chk("t2_busy_done", busy, 0);
        end
        chk("t2_sound_step0", snd_w[0], 1000);
        chk("t2_sound_rest", snd_w[1], 0);
        chk("t2_sound_step2", snd_w[2], 1000);
        chk("t2_pulses_step0", se_w[0], 2);
        chk("t2_pulses_rest", se_w[1], 0);
        chk("t2_pulses_step2", se_w[2], 2);
        chk("t2_rest_cycles", n_rest, 1001);

        // Retrigger effect 0 in the cycle before C5's first step_en would appear
        pulse_start(2'd1);
        repeat (372) tick();
        chk("t3_sound_before", sound_en, 1);
        start = 1'b1; effect_id = 2'd0;
        tick();
        start = 1'b0;
        chk("t3_no_step_en_retrig", step_en, 0);
        chk("t3_sound_gap", sound_en, 0);
        chk("t3_busy", busy, 1);
        tick();
        chk("t3_note_a4", note_idx, 6);
        chk("t3_sound_on", sound_en, 1);
        n_se = int'(step_en);
        for (int j = 376; j <= 817; j++) begin
            tick();
            n_se += int'(step_en);
        end
        chk("t3_early_pulses", n_se, 0);
        tick();
        chk("t3_first_pulse", step_en, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_busy", busy, 0);
        chk("t3_stop_sound", sound_en, 0);

        // Simultaneous stop and start during PLAY
        pulse_start(2'd3);
        repeat (99) tick();
        chk("t4_sound_before", sound_en, 1);
        stop = 1'b1; start = 1'b1; effect_id = 2'd0;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("t4_outputs_off", {busy, sound_en, step_en}, 0);
        chk("t4_note_cleared", note_idx, 0);
        repeat (3) tick();
        chk("t4_start_ignored", busy, 0);

        // 16 steps without last: dur=0 first step, divider-1 CLICK second
        pulse_start(2'd2);
        n_se = 0; n_snd = 0;
        for (int j = 2; j <= 16018; j++) begin
            tick();
            if (j >= 1003 && j <= 2002) begin
                n_se  += int'(step_en);
                n_snd += int'(sound_en);
            end
            if (j == 2)     chk("t5_note_c4", note_idx, 1);
            if (j == 1003)  chk("t5_dur0_is_1ms", note_idx, 15);
            if (j == 15017) chk("t5_note_step15", note_idx, 14);
            if (j == 16016) chk("t5_busy_step15", busy, 1);
            if (j == 16017) chk("t5_end_after_15", busy, 0);
        end
        chk("t5_div1_no_step_en", n_se, 0);
        chk("t5_div1_silent", n_snd, 0);

        // Asynchronous reset in the middle of PLAY
        pulse_start(2'd3);
        repeat (50) tick();
        chk("t6_sound_before", sound_en, 1);
        #2 resetN = 1'b0;
        #1 chk("t6_async_reset", {busy, step_en, sound_en, note_idx}, 0);
        tick();
        tick();
        resetN = 1'b1;
        tick();
        chk("t6_idle_after", busy, 0);
        pulse_start(2'd0);
        chk("t6_restart_busy", busy, 1);
        tick();
        chk("t6_restart_note", note_idx, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
